gci_hub_specialmem_n: RTL and testbench
=======================================

# gci_hub_specialmem_n

Parametrised GCI hub special-memory block for NODE_NUM nodes. It holds a snapshot of every node's memory size and priority, and a total-memory register. The total is computed by a sequential accumulator after each update. Hub-side reads use a registered request/busy/valid handshake and one-cycle latency. It sits between the GCI hub read path and the per-node configuration inputs, replacing the fixed four-node combinational table.

## Interface
- NODE_NUM, 4, number of GCI nodes; legal range 1..8.
- PRI_W, 8, priority field width; legal range 1..32.
- HUB_RSV, 32'h400, hub-reserved memory size added to the total.

- iCLOCK  in  1  system clock; all state changes on its rising edge.
- iRESET_SYNC  in  1  reset, synchronous, active-high.
- iUPDATE_REQ  in  1  single-cycle pulse: capture all node inputs and start the summation.
- iNODE_USEMEMSIZE  in  NODE_NUM*32  node k usemem is in bits [32k+31:32k].
- iNODE_PRIORITY  in  NODE_NUM*PRI_W  node k priority is in bits [PRI_W*k+PRI_W-1:PRI_W*k].
- iREAD_REQ  in  1  read request; accepted only when oBUSY=0.
- iREAD_ADDR  in  10  byte address of the read.
- oBUSY  out  1  summation in progress; read requests are not accepted.
- oDATA_VALID  out  1  read data valid; one-cycle pulse per accepted read.
- oDATA  out  32  read data.
- oDATA_ERR  out  1  accepted read hit an unmapped address; qualified by oDATA_VALID.

## Operation
- Address map (read-only):
  - 0x000: NODE_NUM, zero-extended.
  - 0x004: TOTAL register.
  - 0x008: {31'b0, OVF}.
  - Node k at 0x100+0x20*k: +0x0 is snapshot usemem[k]; +0x4 is snapshot priority[k], zero-extended to 32 bits.
- Any other address, including node slots k ≥ NODE_NUM, is unmapped: oDATA=0 and oDATA_ERR=1.
- Snapshot registers:
  - Loaded from the node inputs in any cycle where iUPDATE_REQ=1, regardless of state.
  - Otherwise they hold their value. Live inputs are never read directly.
- Summation FSM has two states, IDLE and SUM.
  - IDLE + iUPDATE_REQ → SUM. The accumulator is loaded with {1'b0, HUB_RSV} and the index with 0.
  - In SUM, each cycle adds snapshot usemem[idx] to the 33-bit accumulator and increments idx.
  - On the add with idx=NODE_NUM-1:
    - TOTAL ← acc[31:0] + usemem[idx], modulo 2^32.
    - OVF ← carry out of the full 33-bit sum; the accumulator does not saturate.
    - The FSM returns to IDLE.
  - iUPDATE_REQ while in SUM: snapshots are recaptured, the accumulator is reloaded, idx resets to 0, and the FSM stays in SUM. Only the completing pass writes TOTAL/OVF.
- oBUSY = (state==SUM).
- Read handshake:
  - A read is accepted in a cycle with iREAD_REQ=1 and oBUSY=0.
  - Requests presented while oBUSY=1 are dropped. The requester must hold or retry; the block does not queue them.
- Read data is sampled from register state before the same-edge update. A read accepted in the same cycle as iUPDATE_REQ returns the pre-update snapshot and TOTAL.
- Reset values:
  - Snapshots = 0; TOTAL = HUB_RSV; OVF = 0; FSM = IDLE; idx = 0.
  - oBUSY = 0; oDATA_VALID = 0; oDATA = 0; oDATA_ERR = 0.
- Reset asserted mid-SUM aborts the pass. The partial sum is discarded and TOTAL returns to HUB_RSV.

## Timing
- Read latency is one cycle. A request accepted at edge t gives oDATA_VALID=1 with oDATA/oDATA_ERR in cycle t+1.
  - oDATA_VALID falls the next cycle unless another read is accepted; back-to-back reads give one result per cycle.
  - oDATA holds its last value while oDATA_VALID=0.
- Update latency:
  - iUPDATE_REQ sampled at edge t sets oBUSY=1 from t+1 for exactly NODE_NUM cycles.
  - oBUSY=0 and the new TOTAL is readable from cycle t+NODE_NUM+1.
  - The earliest read returning the new TOTAL has valid data at t+NODE_NUM+2.
- iUPDATE_REQ held high restarts the pass every cycle, keeping oBUSY=1 until one cycle after the last high cycle plus NODE_NUM-1 cycles.
- The only combinational output is oBUSY, decoded from the state register. No combinational path runs from inputs to outputs.

## Test plan
- Reset then read 0x000, 0x004, 0x008 with NODE_NUM=4 → 4, 0x400, 0 with oDATA_ERR=0 each time, each one cycle after acceptance.
- Update with usemem={0x1000,0x2000,0x3000,0x4000} and priority={1,2,3,4} → oBUSY high for 4 cycles. Then 0x004 reads 0xA400; 0x104 reads 1; 0x124 reads 2; 0x164 reads 4; 0x160 reads 0x4000.
- Update with usemem={0xFFFFFF00,0x200,0,0} → TOTAL=0x500, OVF=1.
- Read 0x180 and 0x010 → oDATA=0, oDATA_ERR=1. Hold iREAD_REQ high during oBUSY → no oDATA_VALID until oBUSY falls.
- Read and update in the same cycle, then a second update 2 cycles into SUM → first read returns the old TOTAL. oBUSY spans 2+NODE_NUM cycles and TOTAL reflects the second snapshot only.
- iRESET_SYNC asserted in cycle 2 of SUM → oBUSY=0 next cycle; 0x004 reads 0x400 and 0x100 reads 0. Repeat with NODE_NUM=1 and NODE_NUM=8 for map bounds.

Source files
------------

// File: rtl/gci_hub_specialmem_n.sv
// GCI hub special memory: per-node usemem/priority snapshots, a sequentially
// accumulated TOTAL/OVF pair, and a one-cycle-latency registered read port.
module gci_hub_specialmem_n #(
  parameter int          NODE_NUM = 4,
  parameter int          PRI_W    = 8,
  parameter logic [31:0] HUB_RSV  = 32'h400
) (
  input  logic                      iCLOCK,
  input  logic                      iRESET_SYNC,
  input  logic                      iUPDATE_REQ,
  input  logic [NODE_NUM*32-1:0]    iNODE_USEMEMSIZE,
  input  logic [NODE_NUM*PRI_W-1:0] iNODE_PRIORITY,
  input  logic                      iREAD_REQ,
  input  logic [9:0]                iREAD_ADDR,
  output logic                      oBUSY,
  output logic                      oDATA_VALID,
  output logic [31:0]               oDATA,
  output logic                      oDATA_ERR
);

  typedef enum logic {IDLE, SUM} state_t;

  state_t      state_reg;
  logic [2:0]  idx_reg;
  logic [32:0] acc_reg;
  logic [31:0] total_reg;
  logic        ovf_reg;

  logic [31:0]      snap_mem_reg [NODE_NUM];
  logic [PRI_W-1:0] snap_pri_reg [NODE_NUM];

  // Snapshots padded out to the full 8-slot map so every 3-bit index is legal.
  logic [31:0] mem_pad [8];
  logic [31:0] pri_pad [8];

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_slot
      if (gi < NODE_NUM) begin : g_node
        always_ff @(posedge iCLOCK) begin
          if (iRESET_SYNC) begin
            snap_mem_reg[gi] <= '0;
            snap_pri_reg[gi] <= '0;
          end else if (iUPDATE_REQ) begin
            snap_mem_reg[gi] <= iNODE_USEMEMSIZE[32*gi +: 32];
            snap_pri_reg[gi] <= iNODE_PRIORITY[PRI_W*gi +: PRI_W];
          end
        end
        assign mem_pad[gi] = snap_mem_reg[gi];
        assign pri_pad[gi] = 32'(snap_pri_reg[gi]);
      end else begin : g_empty
        assign mem_pad[gi] = '0;
        assign pri_pad[gi] = '0;
      end
    end
  endgenerate

  logic [32:0] sum_next;
  logic        last_add;

  assign sum_next = acc_reg + {1'b0, mem_pad[idx_reg]};
  assign last_add = (idx_reg == 3'(NODE_NUM - 1));

  // A new update always restarts the pass; only a completing pass commits.
  always_ff @(posedge iCLOCK) begin
    if (iRESET_SYNC) begin
      state_reg <= IDLE;
      idx_reg   <= '0;
      acc_reg   <= '0;
      total_reg <= HUB_RSV;
      ovf_reg   <= 1'b0;
    end else if (iUPDATE_REQ) begin
      state_reg <= SUM;
      idx_reg   <= '0;
      acc_reg   <= {1'b0, HUB_RSV};
    end else if (state_reg == SUM) begin
      if (last_add) begin
        total_reg <= sum_next[31:0];
        ovf_reg   <= sum_next[32];
        idx_reg   <= '0;
        state_reg <= IDLE;
      end else begin
        acc_reg <= sum_next;
        idx_reg <= idx_reg + 3'd1;
      end
    end
  end

  assign oBUSY = (state_reg == SUM);

  logic        accept;
  logic [2:0]  node_k;
  logic [31:0] rd_data;
  logic        rd_err;

  assign accept = iREAD_REQ && (state_reg == IDLE);
  assign node_k = iREAD_ADDR[7:5];

  always_comb begin
    rd_data = '0;
    rd_err  = 1'b1;
    case (iREAD_ADDR)
      10'h000: begin rd_data = 32'(NODE_NUM);      rd_err = 1'b0; end
      10'h004: begin rd_data = total_reg;          rd_err = 1'b0; end
      10'h008: begin rd_data = {31'b0, ovf_reg};   rd_err = 1'b0; end
      default: begin
        if (iREAD_ADDR[9:8] == 2'b01 && {1'b0, node_k} < 4'(NODE_NUM)) begin
          if (iREAD_ADDR[4:0] == 5'h00) begin
            rd_data = mem_pad[node_k];
            rd_err  = 1'b0;
          end else if (iREAD_ADDR[4:0] == 5'h04) begin
            rd_data = pri_pad[node_k];
            rd_err  = 1'b0;
          end
        end
      end
    endcase
  end

  always_ff @(posedge iCLOCK) begin
    if (iRESET_SYNC) begin
      oDATA_VALID <= 1'b0;
      oDATA       <= '0;
      oDATA_ERR   <= 1'b0;
    end else begin
      oDATA_VALID <= accept;
      if (accept) begin
        oDATA     <= rd_data;
        oDATA_ERR <= rd_err;
      end
    end
  end

endmodule

// File: tb/tb_gci_hub_specialmem_n.sv
// Directed bench for gci_hub_specialmem_n: NODE_NUM=4 main instance plus
// NODE_NUM=1 and NODE_NUM=8 instances sharing the same stimulus for map bounds.
module tb_gci_hub_specialmem_n;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         upd = 1'b0;
  logic         req = 1'b0;
  logic [9:0]   addr = '0;
  logic [255:0] mem_bus = '0;
  logic [63:0]  pri_bus = '0;

  logic b4, v4, e4, b1, v1, e1, b8, v8, e8;
  logic [31:0] d4, d1, d8;

  int cmp_cnt = 0;
  int err_cnt = 0;

  always #5 clk = ~clk;

  gci_hub_specialmem_n #(.NODE_NUM(4), .PRI_W(8), .HUB_RSV(32'h400)) u_n4 (
    .iCLOCK(clk), .iRESET_SYNC(rst), .iUPDATE_REQ(upd),
    .iNODE_USEMEMSIZE(mem_bus[127:0]), .iNODE_PRIORITY(pri_bus[31:0]),
    .iREAD_REQ(req), .iREAD_ADDR(addr),
    .oBUSY(b4), .oDATA_VALID(v4), .oDATA(d4), .oDATA_ERR(e4));

  gci_hub_specialmem_n #(.NODE_NUM(1), .PRI_W(8), .HUB_RSV(32'h400)) u_n1 (
    .iCLOCK(clk), .iRESET_SYNC(rst), .iUPDATE_REQ(upd),
    .iNODE_USEMEMSIZE(mem_bus[31:0]), .iNODE_PRIORITY(pri_bus[7:0]),
    .iREAD_REQ(req), .iREAD_ADDR(addr),
    .oBUSY(b1), .oDATA_VALID(v1), .oDATA(d1), .oDATA_ERR(e1));

  gci_hub_specialmem_n #(.NODE_NUM(8), .PRI_W(8), .HUB_RSV(32'h400)) u_n8 (
    .iCLOCK(clk), .iRESET_SYNC(rst), .iUPDATE_REQ(upd),
    .iNODE_USEMEMSIZE(mem_bus), .iNODE_PRIORITY(pri_bus),
    .iREAD_REQ(req), .iREAD_ADDR(addr),
    .oBUSY(b8), .oDATA_VALID(v8), .oDATA(d8), .oDATA_ERR(e8));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    cmp_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_node(input int k, input logic [31:0] m, input logic [7:0] p);
    mem_bus[32*k +: 32] = m;
    pri_bus[8*k +: 8]   = p;
  endtask

  // Issue one read while idle; returns at the negedge of the result cycle.
  task automatic rd(input logic [9:0] a);
    @(negedge clk);
    req  = 1'b1;
    addr = a;
    @(negedge clk);
    req  = 1'b0;
    $display("read 0x%03h: n4 v=%0d d=0x%0h e=%0d | n1 v=%0d d=0x%0h e=%0d | n8 v=%0d d=0x%0h e=%0d",
             a, v4, d4, e4, v1, d1, e1, v8, d8, e8);
  endtask

  task automatic chk_n4(input string tag, input logic [31:0] exp_d, input logic exp_e);
    chk({tag, "_v"}, 32'(v4), 32'd1);
    chk({tag, "_d"}, d4, exp_d);
    chk({tag, "_e"}, 32'(e4), 32'(exp_e));
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 30; i++) begin
      if (!(b4 | b1 | b8)) break;
      @(negedge clk);
    end
    chk("idle_timeout", 32'(b4 | b1 | b8), 32'd0);
  endtask

  task automatic pulse_update();
    @(negedge clk);
    upd = 1'b1;
    @(negedge clk);
    upd = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    int vbusy;

    // Reset state and identity registers
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_busy", 32'(b4), 32'd0);
    chk("rst_valid", 32'(v4), 32'd0);
    chk("rst_data", d4, 32'd0);
    chk("rst_err", 32'(e4), 32'd0);
    rd(10'h000); chk_n4("nodenum", 32'd4, 1'b0);
    rd(10'h004); chk_n4("total_rst", 32'h400, 1'b0);
    rd(10'h008); chk_n4("ovf_rst", 32'd0, 1'b0);
    @(negedge clk);
    chk("valid_fall", 32'(v4), 32'd0);

    // Basic update: 0x400 + 0x1000+0x2000+0x3000+0x4000 = 0xA400
    set_node(0, 32'h1000, 8'd1);
    set_node(1, 32'h2000, 8'd2);
    set_node(2, 32'h3000, 8'd3);
    set_node(3, 32'h4000, 8'd4);
    pulse_update();
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (!b4) break;
      cnt++;
      @(negedge clk);
    end
    chk("busy_len", 32'(cnt), 32'd4);
    wait_idle();
    rd(10'h004); chk_n4("total_a400", 32'hA400, 1'b0);
    rd(10'h104); chk_n4("pri0", 32'd1, 1'b0);
    rd(10'h124); chk_n4("pri1", 32'd2, 1'b0);
    rd(10'h164); chk_n4("pri3", 32'd4, 1'b0);
    rd(10'h160); chk_n4("mem3", 32'h4000, 1'b0);
    rd(10'h008); chk_n4("ovf0", 32'd0, 1'b0);

    // Overflow: 0x400 + 0xFFFFFF00 + 0x200 wraps to 0x500 with carry
    set_node(0, 32'hFFFFFF00, 8'd1);
    set_node(1, 32'h200, 8'd2);
    set_node(2, 32'h0, 8'd3);
    set_node(3, 32'h0, 8'd4);
    pulse_update();
    wait_idle();
    rd(10'h004); chk_n4("total_ovf", 32'h500, 1'b0);
    rd(10'h008); chk_n4("ovf1", 32'd1, 1'b0);

    // Unmapped addresses
    rd(10'h180); chk_n4("unmap_180", 32'd0, 1'b1);
    rd(10'h010); chk_n4("unmap_010", 32'd0, 1'b1);

    // Read held during busy is dropped until busy falls
    pulse_update();
    req  = 1'b1;
    addr = 10'h004;
    cnt   = 0;
    vbusy = 0;
    for (int i = 0; i < 20; i++) begin
      if (!b4) break;
      cnt++;
      if (v4) vbusy++;
      @(negedge clk);
    end
    chk("hold_busy_len", 32'(cnt), 32'd4);
    chk("hold_valid_in_busy", 32'(vbusy), 32'd0);
    chk("hold_valid_at_fall", 32'(v4), 32'd0);
    @(negedge clk);
    req = 1'b0;
    chk_n4("hold_read", 32'h500, 1'b0);
    @(negedge clk);
    chk("hold_valid_drop", 32'(v4), 32'd0);
    chk("hold_data_keep", d4, 32'h500);
    wait_idle();

    // Read with update in same cycle, then restart 2 cycles into SUM
    for (int k = 0; k < 4; k++) set_node(k, 32'h100, 8'd0);
    @(negedge clk);
    upd  = 1'b1;
    req  = 1'b1;
    addr = 10'h004;
    @(negedge clk);
    upd = 1'b0;
    req = 1'b0;
    chk_n4("same_cycle_old_total", 32'h500, 1'b0);
    cnt = 1;
    for (int k = 0; k < 4; k++) set_node(k, 32'(k + 1), 8'(k + 9));
    @(negedge clk);
    if (b4) cnt++;
    upd = 1'b1;
    @(negedge clk);
    upd = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (!b4) break;
      cnt++;
      @(negedge clk);
    end
    chk("restart_busy_len", 32'(cnt), 32'd6);
    wait_idle();
    rd(10'h004); chk_n4("restart_total", 32'h40A, 1'b0);
    rd(10'h100); chk_n4("restart_mem0", 32'd1, 1'b0);
    rd(10'h124); chk_n4("restart_pri1", 32'd10, 1'b0);

    // Reset in the second SUM cycle aborts the pass
    for (int k = 0; k < 4; k++) set_node(k, 32'h7000, 8'd5);
    pulse_update();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", 32'(b4), 32'd0);
    chk("abort_valid", 32'(v4), 32'd0);
    wait_idle();
    rd(10'h004); chk_n4("abort_total", 32'h400, 1'b0);
    rd(10'h100); chk_n4("abort_mem0", 32'd0, 1'b0);
    rd(10'h008); chk_n4("abort_ovf", 32'd0, 1'b0);

    // Map bounds for NODE_NUM = 1 / 4 / 8
    for (int k = 0; k < 8; k++) set_node(k, 32'(16 * (k + 1)), 8'(k + 1));
    pulse_update();
    wait_idle();
    rd(10'h000);
    chk("n1_num", d1, 32'd1);
    chk("n8_num", d8, 32'd8);
    rd(10'h004);
    chk("n1_total", d1, 32'h410);
    chk("n4_total", d4, 32'h4A0);
    chk("n8_total", d8, 32'h640);
    rd(10'h120);
    chk("n1_slot1_err", 32'(e1), 32'd1);
    chk("n1_slot1_d", d1, 32'd0);
    chk("n8_slot1_d", d8, 32'h20);
    rd(10'h1E0);
    chk("n8_slot7_mem", d8, 32'h80);
    chk("n8_slot7_err", 32'(e8), 32'd0);
    chk("n4_slot7_err", 32'(e4), 32'd1);
    rd(10'h1E4);
    chk("n8_slot7_pri", d8, 32'd8);
    rd(10'h200);
    chk("n8_200_err", 32'(e8), 32'd1);
    chk("n8_200_d", d8, 32'd0);
    chk("n1_200_err", 32'(e1), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
